// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: state codes, requester
// indices and latency-counter width.
package mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE   = 2'b00;
    localparam logic [1:0] ARB_ACCESS = 2'b01;
    localparam logic [1:0] ARB_DONE   = 2'b10;

    localparam logic ARB_REQ_CPU = 1'b0;
    localparam logic ARB_REQ_LDR = 1'b1;

    // Four bits cover every legal MEM_LATENCY (1..15).
    localparam int unsigned ARB_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        StIdle   = ARB_IDLE,
        StAccess = ARB_ACCESS,
        StDone   = ARB_DONE
    } arb_state_e;

    function automatic logic [1:0] arb_onehot(input logic idx);
        return (idx == ARB_REQ_LDR) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter with zero flag; times how long the memory strobes stay asserted.
module mem_arb_lat_cnt
    import mem_arbiter_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic [ARB_CNT_WIDTH-1:0] load_val_i,
    input  logic                     dec_i,
    output logic [ARB_CNT_WIDTH-1:0] cnt_o,
    output logic                     zero_o
);

    logic [ARB_CNT_WIDTH-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter (CPU vs. loader). Round-robin on ties unless
// MEM_ARB_CPU_PRIO_EN is defined, which gives the CPU fixed priority. MEM_LATENCY: 1..15.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 26,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic                  RNW0,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [DATA_WIDTH-1:0] WDATA0,
    output logic                  ACK0,
    input  logic                  REQ1,
    input  logic                  RNW1,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WDATA1,
    output logic                  ACK1,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            GNT,
    output logic                  BUSY,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA
);

    localparam logic [ARB_CNT_WIDTH-1:0] LatLoad = ARB_CNT_WIDTH'(MEM_LATENCY - 1);

    arb_state_e state_d, state_q;

    logic                  owner_d, owner_q;
    logic                  rnw_d, rnw_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

    logic                     any_req;
    logic                     launch;
    logic                     winner;
    logic                     cnt_dec;
    logic                     cnt_zero;
    logic [ARB_CNT_WIDTH-1:0] cnt_val;

    assign any_req = REQ0 | REQ1;
    assign launch  = (state_q == StIdle) && any_req;
    assign cnt_dec = (state_q == StAccess);

`ifdef MEM_ARB_CPU_PRIO_EN
    always_comb begin
        winner = REQ0 ? ARB_REQ_CPU : ARB_REQ_LDR;
    end
`else
    // rr_q holds the last winner; on a tie the other requester is served.
    logic rr_d, rr_q;

    always_comb begin
        if (REQ0 && REQ1) begin
            winner = ~rr_q;
        end else begin
            winner = REQ1 ? ARB_REQ_LDR : ARB_REQ_CPU;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (launch) begin
            rr_d = winner;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rr_q <= ARB_REQ_LDR;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    mem_arb_lat_cnt u_lat_cnt (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .load_i     (launch),
        .load_val_i (LatLoad),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_zero) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Transaction latch and read-data capture
    always_comb begin
        owner_d = owner_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (launch) begin
            owner_d = winner;
            rnw_d   = (winner == ARB_REQ_LDR) ? RNW1   : RNW0;
            addr_d  = (winner == ARB_REQ_LDR) ? ADDR1  : ADDR0;
            wdata_d = (winner == ARB_REQ_LDR) ? WDATA1 : WDATA0;
        end
        if ((state_q == StAccess) && cnt_zero && rnw_q) begin
            rdata_d = MEM_RDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            owner_q <= ARB_REQ_CPU;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decoded from the registered state so reset clears them at once
    always_comb begin
        GNT       = 2'b00;
        BUSY      = 1'b0;
        ACK0      = 1'b0;
        ACK1      = 1'b0;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        unique case (state_q)
            StAccess: begin
                GNT       = arb_onehot(owner_q);
                BUSY      = 1'b1;
                MEM_READ  = rnw_q;
                MEM_WRITE = ~rnw_q;
                MEM_ADDR  = addr_q;
                MEM_WDATA = wdata_q;
            end
            StDone: begin
                GNT  = arb_onehot(owner_q);
                BUSY = 1'b1;
                ACK0 = (owner_q == ARB_REQ_CPU);
                ACK1 = (owner_q == ARB_REQ_LDR);
            end
            default: begin
            end
        endcase
    end

    assign RDATA = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned AW  = 26;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;
`ifdef MEM_ARB_CPU_PRIO_EN
    localparam bit CpuPrio = 1'b1;
`else
    localparam bit CpuPrio = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req0, rnw0, ack0, req1, rnw1, ack1;
    logic [AW-1:0] addr0, addr1, mem_addr;
    logic [DW-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
    logic [1:0]    gnt;
    logic          busy, mem_read, mem_write;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
        .CLK(clk), .RST(rst_n),
        .REQ0(req0), .RNW0(rnw0), .ADDR0(addr0), .WDATA0(wdata0), .ACK0(ack0),
        .REQ1(req1), .RNW1(rnw1), .ADDR1(addr1), .WDATA1(wdata1), .ACK1(ack1),
        .RDATA(rdata), .GNT(gnt), .BUSY(busy), .MEM_READ(mem_read), .MEM_WRITE(mem_write),
        .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata)
    );

    // Second instance exercising the single-cycle latency build
    logic          l1_req0, l1_rnw0, l1_ack0, l1_req1, l1_rnw1, l1_ack1;
    logic [AW-1:0] l1_addr0, l1_addr1, l1_mem_addr;
    logic [DW-1:0] l1_wdata0, l1_wdata1, l1_rdata, l1_mem_wdata, l1_mem_rdata;
    logic [1:0]    l1_gnt;
    logic          l1_busy, l1_mem_read, l1_mem_write;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut_l1 (
        .CLK(clk), .RST(rst_n),
        .REQ0(l1_req0), .RNW0(l1_rnw0), .ADDR0(l1_addr0), .WDATA0(l1_wdata0), .ACK0(l1_ack0),
        .REQ1(l1_req1), .RNW1(l1_rnw1), .ADDR1(l1_addr1), .WDATA1(l1_wdata1), .ACK1(l1_ack1),
        .RDATA(l1_rdata), .GNT(l1_gnt), .BUSY(l1_busy), .MEM_READ(l1_mem_read),
        .MEM_WRITE(l1_mem_write), .MEM_ADDR(l1_mem_addr), .MEM_WDATA(l1_mem_wdata),
        .MEM_RDATA(l1_mem_rdata)
    );

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_rdata;
    logic          last_win;

    // Arbitration rule: lone requester wins; on a tie the one not served last (or CPU).
    function automatic logic pick(input logic r0, input logic r1);
        if (r0 && r1) return CpuPrio ? 1'b0 : ~last_win;
        return r1;
    endfunction

    // Entered and left just after a falling edge with the DUT idle.
    task automatic run_txn(input logic who, input logic rnw, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        logic [1:0] eg;
        if (who) begin req1 = 1; rnw1 = rnw; addr1 = a; wdata1 = wd; end
        else     begin req0 = 1; rnw0 = rnw; addr0 = a; wdata0 = wd; end
        eg = who ? 2'b10 : 2'b01;
        @(posedge clk);
        last_win = who;
        for (int c = 1; c <= int'(LAT); c++) begin
            #1;
            mem_rdata = (c == int'(LAT)) ? rd : DW'($urandom);
            if (who) begin addr1 = AW'($urandom); wdata1 = DW'($urandom); rnw1 = 1'($urandom); end
            else     begin addr0 = AW'($urandom); wdata0 = DW'($urandom); rnw0 = 1'($urandom); end
            @(negedge clk);
            checks++; if (mem_read !== rnw) begin errors++;
                $display("FAIL acc_read c=%0d got=%b want=%b", c, mem_read, rnw); end
            checks++; if (mem_write !== !rnw) begin errors++;
                $display("FAIL acc_write c=%0d got=%b want=%b", c, mem_write, !rnw); end
            checks++; if (mem_addr !== a) begin errors++;
                $display("FAIL acc_addr c=%0d got=%h want=%h", c, mem_addr, a); end
            checks++; if (mem_wdata !== wd) begin errors++;
                $display("FAIL acc_wdata c=%0d got=%h want=%h", c, mem_wdata, wd); end
            checks++; if ({gnt, busy, ack0, ack1} !== {eg, 3'b100}) begin errors++;
                $display("FAIL acc_ctl c=%0d got gnt/busy/acks=%b want=%b", c,
                         {gnt, busy, ack0, ack1}, {eg, 3'b100}); end
            checks++; if (rdata !== exp_rdata) begin errors++;
                $display("FAIL acc_rdata c=%0d got=%h want=%h", c, rdata, exp_rdata); end
            @(posedge clk);
        end
        if (rnw) exp_rdata = rd;
        #1 mem_rdata = DW'($urandom);
        @(negedge clk);
        checks++; if ({ack0, ack1} !== {!who, who}) begin errors++;
            $display("FAIL done_ack got=%b want=%b", {ack0, ack1}, {!who, who}); end
        checks++; if ({mem_read, mem_write, gnt, busy} !== {2'b00, eg, 1'b1}) begin errors++;
            $display("FAIL done_ctl got=%b want=%b", {mem_read, mem_write, gnt, busy},
                     {2'b00, eg, 1'b1}); end
        checks++; if (rdata !== exp_rdata) begin errors++;
            $display("FAIL done_rdata got=%h want=%h", rdata, exp_rdata); end
        req0 = 0; req1 = 0;
        @(negedge clk);
        checks++; if ({gnt, busy, ack0, ack1, mem_read, mem_write} !== 7'b0) begin errors++;
            $display("FAIL idle_ctl got=%b want=0", {gnt, busy, ack0, ack1, mem_read, mem_write});
        end
        checks++; if (rdata !== exp_rdata) begin errors++;
            $display("FAIL idle_rdata got=%h want=%h", rdata, exp_rdata); end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        checks++; if ({gnt, busy, ack0, ack1, mem_read, mem_write} !== 7'b0) begin errors++;
            $display("FAIL reset_ctl got=%b want=0", {gnt, busy, ack0, ack1, mem_read, mem_write});
        end
        checks++; if ({rdata, mem_addr, mem_wdata} !== '0) begin errors++;
            $display("FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", rdata, mem_addr,
                     mem_wdata); end
        exp_rdata = '0;
        last_win  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic();
        run_txn(1'b0, 1'b1, 26'h0000010, 32'h0, 32'hDEADBEEF);
        run_txn(1'b1, 1'b0, 26'h0000100, 32'h12345678, 32'hCAFEF00D);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_txn(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
        end
    endtask

    task automatic test_contention();
        logic          w;
        logic [AW-1:0] a0, a1;
        a0 = 26'h0000040; a1 = 26'h0000080;
        req0 = 1; rnw0 = 0; addr0 = a0; wdata0 = 32'h0A0A0A0A;
        req1 = 1; rnw1 = 0; addr1 = a1; wdata1 = 32'h1B1B1B1B;
        for (int n = 0; n < 4; n++) begin
            w = pick(1'b1, 1'b1);
            @(posedge clk);
            last_win = w;
            for (int c = 1; c <= int'(LAT) + 1; c++) begin
                @(negedge clk);
                if (c <= int'(LAT)) begin
                    checks++; if ({gnt, mem_write, ack0, ack1} !== {(w ? 2'b10 : 2'b01), 3'b100})
                    begin errors++;
                        $display("FAIL cont_acc n=%0d c=%0d got=%b want=%b", n, c,
                                 {gnt, mem_write, ack0, ack1}, {(w ? 2'b10 : 2'b01), 3'b100});
                    end
                    checks++; if (mem_addr !== (w ? a1 : a0)) begin errors++;
                        $display("FAIL cont_addr n=%0d got=%h want=%h", n, mem_addr,
                                 (w ? a1 : a0)); end
                end else begin
                    checks++; if ({ack0, ack1} !== {!w, w}) begin errors++;
                        $display("FAIL cont_ack n=%0d got=%b want=%b", n, {ack0, ack1}, {!w, w});
                    end
                    if (n == 3) begin req0 = 0; req1 = 0; end
                end
            end
            @(negedge clk);
            checks++; if ({gnt, busy, ack0, ack1} !== 5'b0) begin errors++;
                $display("FAIL cont_idle n=%0d got=%b want=0", n, {gnt, busy, ack0, ack1}); end
        end
        checks++; if (rdata !== exp_rdata) begin errors++;
            $display("FAIL cont_rdata got=%h want=%h", rdata, exp_rdata); end
    endtask

    task automatic test_reset_midaccess();
        req0 = 1; rnw0 = 1; addr0 = 26'h0000010;
        @(posedge clk);
        #1 mem_rdata = DW'($urandom);
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        exp_rdata = '0;
        last_win  = 1'b1;
        checks++; if ({mem_read, gnt, busy, ack0} !== 5'b0) begin errors++;
            $display("FAIL rst_mid got=%b want=0", {mem_read, gnt, busy, ack0}); end
        checks++; if (rdata !== '0) begin errors++;
            $display("FAIL rst_mid_rdata got=%h want=0", rdata); end
        @(negedge clk);
        checks++; if ({ack0, ack1, busy} !== 3'b0) begin errors++;
            $display("FAIL rst_hold got=%b want=0", {ack0, ack1, busy}); end
        rst_n = 1;
        run_txn(1'b0, 1'b1, 26'h0000010, 32'h0, 32'h5A5AA5A5);
    endtask

    task automatic test_latency1();
        l1_req0 = 1; l1_rnw0 = 1; l1_addr0 = 26'h0000033;
        @(posedge clk);
        #1 l1_mem_rdata = 32'h600DF00D;
        @(negedge clk);
        checks++; if ({l1_mem_read, l1_mem_write, l1_ack0, l1_gnt} !== 5'b10001) begin errors++;
            $display("FAIL l1_acc got=%b want=10001", {l1_mem_read, l1_mem_write, l1_ack0, l1_gnt});
        end
        checks++; if (l1_mem_addr !== 26'h0000033) begin errors++;
            $display("FAIL l1_addr got=%h want=0000033", l1_mem_addr); end
        @(posedge clk);
        #1 l1_mem_rdata = 32'h0;
        @(negedge clk);
        checks++; if ({l1_ack0, l1_ack1, l1_mem_read} !== 3'b100) begin errors++;
            $display("FAIL l1_done got=%b want=100", {l1_ack0, l1_ack1, l1_mem_read}); end
        checks++; if (l1_rdata !== 32'h600DF00D) begin errors++;
            $display("FAIL l1_rdata got=%h want=600df00d", l1_rdata); end
        l1_req0 = 0;
        @(negedge clk);
        checks++; if ({l1_ack0, l1_busy, l1_gnt} !== 4'b0) begin errors++;
            $display("FAIL l1_idle got=%b want=0", {l1_ack0, l1_busy, l1_gnt}); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req0 = 0; rnw0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; rnw1 = 0; addr1 = '0; wdata1 = '0;
        mem_rdata = '0;
        l1_req0 = 0; l1_rnw0 = 0; l1_addr0 = '0; l1_wdata0 = '0;
        l1_req1 = 0; l1_rnw1 = 0; l1_addr1 = '0; l1_wdata1 = '0;
        l1_mem_rdata = '0;
        test_reset();
        test_basic();
        test_random();
        test_contention();
        test_reset_midaccess();
        test_latency1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single memory port between two requesters: requester 0 is the processor control/datapath (fetch, lw, sw, push, pop) and requester 1 is the program loader/DMA port. It arbitrates, latches one transaction, drives the memory READ/WRITE strobes for a fixed number of cycles, and returns read data with a one-cycle ACK. It sits between CONTROL_UNIT/datapath and the memory model.

Parameters:
ADDR_WIDTH, 26, memory word address width
DATA_WIDTH, 32, data word width
MEM_LATENCY, 2, cycles each access holds MEM_READ/MEM_WRITE; legal range 1..15; 0 is illegal

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-low reset
REQ0  input  1  requester 0 (CPU) transaction request
RNW0  input  1  requester 0: 1 = read, 0 = write
ADDR0  input  ADDR_WIDTH  requester 0 address
WDATA0  input  DATA_WIDTH  requester 0 write data
ACK0  output  1  requester 0 transaction complete, one-cycle pulse
REQ1  input  1  requester 1 (loader) transaction request
RNW1  input  1  requester 1: 1 = read, 0 = write
ADDR1  input  ADDR_WIDTH  requester 1 address
WDATA1  input  DATA_WIDTH  requester 1 write data
ACK1  output  1  requester 1 transaction complete, one-cycle pulse
RDATA  output  DATA_WIDTH  read data for the acknowledged requester; shared by both requesters
GNT  output  2  one-hot current owner; 0 when idle
BUSY  output  1  high in ACCESS and DONE
MEM_READ  output  1  memory read strobe
MEM_WRITE  output  1  memory write strobe
MEM_ADDR  output  ADDR_WIDTH  memory address
MEM_WDATA  output  DATA_WIDTH  memory write data
MEM_RDATA  input  DATA_WIDTH  memory read data, valid in the last ACCESS cycle

Behaviour:
- Reset (RST low, asynchronous): state IDLE; all outputs 0; rr pointer = 1 so requester 0 wins the first tie; any in-flight transaction is discarded and no ACK is issued.
- States are IDLE, ACCESS and DONE.
- IDLE: at a rising edge with REQ0 or REQ1 high, select the winner.
  - Only one request: that requester wins.
  - Both requests: the requester other than rr pointer wins.
  - Latch the winner's RNW, ADDR and WDATA; set GNT; rr pointer := winner; load the latency counter with MEM_LATENCY-1; go to ACCESS.
  - With no request, stay in IDLE with GNT=0.
- ACCESS: hold MEM_ADDR and MEM_WDATA from the latched values.
  - MEM_READ = latched RNW; MEM_WRITE = ~latched RNW. Exactly one strobe is high for exactly MEM_LATENCY cycles.
  - Decrement the counter each cycle. When it reaches 0: for a read, capture MEM_RDATA into RDATA; go to DONE.
  - Requester input changes during ACCESS are ignored.
- DONE: both strobes low; ACK of the GNT owner is high for this one cycle; RDATA is valid; next state is IDLE.
  - RDATA holds its value until the next read completes. Writes leave RDATA unchanged.
- Latency: REQ sampled at edge k; strobes asserted in cycles k+1..k+MEM_LATENCY; ACK in cycle k+MEM_LATENCY+1.
  - With MEM_LATENCY=2, a request first sampled at edge 0 gets ACK in cycle 3.
- Handshake: the requester holds REQ and its operands stable until ACK and drops REQ at the edge ending the ACK cycle. A REQ still high in the following IDLE cycle is a new transaction.
- GNT is nonzero only in ACCESS and DONE. ACK0 and ACK1 are never high together.
- A new request cannot start in the DONE cycle; there is a minimum of one IDLE cycle between transactions.
- Reset asserted during ACCESS: strobes drop immediately (asynchronously) and no ACK is issued. After release, arbitration restarts in IDLE.

Optional Feature:
MEM_ARB_CPU_PRIO_EN
- Defined: fixed priority. Requester 0 always wins a tie and the rr pointer is unused. Requester 1 is granted only when REQ0 is low in IDLE.
- Undefined: round-robin as described in Behaviour.
- All timing, ACK rules and reset behaviour are identical in both builds.

Decomposition:
- Shared definitions file (alongside the processor state codes):
  - state encodings ARB_IDLE=2'b00, ARB_ACCESS=2'b01, ARB_DONE=2'b10
  - requester index constants ARB_REQ_CPU=0, ARB_REQ_LDR=1
- One sub-module, mem_arb_lat_cnt: a loadable down-counter with a zero flag and asynchronous active-low reset on CLK/RST. The counter is 4 bits, which covers MEM_LATENCY up to 15.

Test Plan:
- Reset, then REQ0=1, RNW0=1, ADDR0=26'h0000010, memory returns 32'hDEADBEEF → MEM_READ high in cycles 1-2, MEM_ADDR=26'h0000010, ACK0 pulses in cycle 3 with RDATA=32'hDEADBEEF, GNT=2'b01.
- REQ1 write, ADDR1=26'h0000100, WDATA1=32'h12345678 → MEM_WRITE high for 2 cycles, MEM_WDATA=32'h12345678, ACK1 in cycle 3, RDATA unchanged, MEM_READ never high.
- REQ0 and REQ1 both held high continuously after reset → grants alternate 0,1,0,1, each ACK 4 cycles apart. With MEM_ARB_CPU_PRIO_EN defined, ACK0 only.
- During ACCESS, change ADDR0 from 26'h10 to 26'h20 → MEM_ADDR stays 26'h10 throughout the transaction.
- RST low in the 2nd ACCESS cycle of a read → MEM_READ, GNT, BUSY and RDATA go to 0 immediately; no ACK0. After release with REQ0 high, the full transaction completes normally.
- MEM_LATENCY=1 build: read request → single strobe cycle, ACK in cycle 2.
